// File: rtl/apa102_strip_rx.sv
// Two-wire LED-strip receiver: oversamples strip clock/data, aligns on the
// 32-zero start frame and decodes LED frames into indexed pixels.
module apa102_strip_rx #(
  parameter int NUM_LEDS       = 64,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 13,
  localparam int IDX_W         = $clog2(NUM_LEDS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sclk_in,
  input  logic             sdat_in,
  output logic             locked,
  output logic             pix_valid,
  output logic [IDX_W-1:0] pix_idx,
  output logic [4:0]       pix_bright,
  output logic [7:0]       pix_b,
  output logic [7:0]       pix_g,
  output logic [7:0]       pix_r,
  output logic             frame_done,
  output logic [IDX_W:0]   frame_len,
  output logic             err
);

  typedef enum logic [0:0] {
    ST_HUNT  = 1'b0,
    ST_FRAME = 1'b1
  } state_t;

  localparam logic [IDX_W:0]   LP_NUM      = (IDX_W+1)'(NUM_LEDS);
  localparam logic [IDX_W:0]   LP_PIX_ONE  = 1;
  localparam logic [CNT_W-1:0] LP_T_ONE    = 1;
  localparam logic [CNT_W-1:0] LP_TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic r_sclk_s1, r_sclk_s2, r_sclk_d;
  logic r_sdat_s1, r_sdat_s2;

  state_t           r_state, w_state_next;
  // Only 31 bits are stored: the 32nd bit completes the word combinationally.
  logic [30:0]      r_shift, w_shift_next;
  logic [4:0]       r_bitcnt, w_bitcnt_next;
  logic [4:0]       r_zcnt, w_zcnt_next;
  logic [IDX_W:0]   r_pixcnt, w_pixcnt_next;
  logic [CNT_W-1:0] r_tcnt, w_tcnt_next;

  logic             r_locked, w_locked_next;
  logic             r_pix_valid, w_pix_valid_next;
  logic [IDX_W-1:0] r_pix_idx, w_pix_idx_next;
  logic [4:0]       r_pix_bright, w_pix_bright_next;
  logic [7:0]       r_pix_b, w_pix_b_next;
  logic [7:0]       r_pix_g, w_pix_g_next;
  logic [7:0]       r_pix_r, w_pix_r_next;
  logic             r_frame_done, w_frame_done_next;
  logic [IDX_W:0]   r_frame_len, w_frame_len_next;
  logic             r_err, w_err_next;

  logic        w_fall;
  logic [31:0] w_word;

  assign w_fall = r_sclk_d & ~r_sclk_s2;
  assign w_word = {r_shift, r_sdat_s2};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_d  <= 1'b0;
      r_sdat_s1 <= 1'b0;
      r_sdat_s2 <= 1'b0;
    end else begin
      r_sclk_s1 <= sclk_in;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_d  <= r_sclk_s2;
      r_sdat_s1 <= sdat_in;
      r_sdat_s2 <= r_sdat_s1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_HUNT;
      r_shift      <= '0;
      r_bitcnt     <= '0;
      r_zcnt       <= '0;
      r_pixcnt     <= '0;
      r_tcnt       <= '0;
      r_locked     <= 1'b0;
      r_pix_valid  <= 1'b0;
      r_pix_idx    <= '0;
      r_pix_bright <= '0;
      r_pix_b      <= '0;
      r_pix_g      <= '0;
      r_pix_r      <= '0;
      r_frame_done <= 1'b0;
      r_frame_len  <= '0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_shift      <= w_shift_next;
      r_bitcnt     <= w_bitcnt_next;
      r_zcnt       <= w_zcnt_next;
      r_pixcnt     <= w_pixcnt_next;
      r_tcnt       <= w_tcnt_next;
      r_locked     <= w_locked_next;
      r_pix_valid  <= w_pix_valid_next;
      r_pix_idx    <= w_pix_idx_next;
      r_pix_bright <= w_pix_bright_next;
      r_pix_b      <= w_pix_b_next;
      r_pix_g      <= w_pix_g_next;
      r_pix_r      <= w_pix_r_next;
      r_frame_done <= w_frame_done_next;
      r_frame_len  <= w_frame_len_next;
      r_err        <= w_err_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_shift_next      = r_shift;
    w_bitcnt_next     = r_bitcnt;
    w_zcnt_next       = r_zcnt;
    w_pixcnt_next     = r_pixcnt;
    w_tcnt_next       = r_tcnt;
    w_locked_next     = r_locked;
    w_pix_valid_next  = 1'b0;
    w_pix_idx_next    = r_pix_idx;
    w_pix_bright_next = r_pix_bright;
    w_pix_b_next      = r_pix_b;
    w_pix_g_next      = r_pix_g;
    w_pix_r_next      = r_pix_r;
    w_frame_done_next = 1'b0;
    w_frame_len_next  = r_frame_len;
    w_err_next        = 1'b0;

    if (w_fall) begin
      w_shift_next  = w_word[30:0];
      w_bitcnt_next = r_bitcnt + 5'd1;
    end

    case (r_state)
      ST_HUNT: begin
        w_tcnt_next = '0;
        if (w_fall) begin
          if (r_sdat_s2) begin
            w_zcnt_next = '0;
          end else if (r_zcnt == 5'd31) begin
            w_state_next  = ST_FRAME;
            w_bitcnt_next = '0;
            w_pixcnt_next = '0;
            w_zcnt_next   = '0;
            w_locked_next = 1'b1;
          end else begin
            w_zcnt_next = r_zcnt + 5'd1;
          end
        end
      end

      ST_FRAME: begin
        if (w_fall) begin
          w_tcnt_next = '0;
          if (r_bitcnt == 5'd31) begin
            if (w_word[31:29] == 3'b111) begin
              if (r_pixcnt < LP_NUM) begin
                w_pix_valid_next  = 1'b1;
                w_pix_idx_next    = r_pixcnt[IDX_W-1:0];
                w_pix_bright_next = w_word[28:24];
                w_pix_b_next      = w_word[23:16];
                w_pix_g_next      = w_word[15:8];
                w_pix_r_next      = w_word[7:0];
                w_pixcnt_next     = r_pixcnt + LP_PIX_ONE;
              end else begin
                w_err_next = 1'b1;
              end
            end else if (w_word == 32'd0) begin
              if (r_pixcnt != '0) begin
                w_frame_done_next = 1'b1;
                w_frame_len_next  = r_pixcnt;
                w_pixcnt_next     = '0;
              end
            end else begin
              w_err_next    = 1'b1;
              w_locked_next = 1'b0;
              w_state_next  = ST_HUNT;
              w_zcnt_next   = '0;
              w_pixcnt_next = '0;
            end
          end
        end else if (r_bitcnt != 5'd0) begin
          // Strip clock stalled mid-word: abandon the frame after the limit.
          if (r_tcnt == LP_TMO_LAST) begin
            w_err_next    = 1'b1;
            w_locked_next = 1'b0;
            w_state_next  = ST_HUNT;
            w_zcnt_next   = '0;
            w_pixcnt_next = '0;
            w_bitcnt_next = '0;
            w_tcnt_next   = '0;
          end else begin
            w_tcnt_next = r_tcnt + LP_T_ONE;
          end
        end
      end

      default: w_state_next = ST_HUNT;
    endcase
  end

  assign locked     = r_locked;
  assign pix_valid  = r_pix_valid;
  assign pix_idx    = r_pix_idx;
  assign pix_bright = r_pix_bright;
  assign pix_b      = r_pix_b;
  assign pix_g      = r_pix_g;
  assign pix_r      = r_pix_r;
  assign frame_done = r_frame_done;
  assign frame_len  = r_frame_len;
  assign err        = r_err;

endmodule

// File: tb/tb_apa102_strip_rx.sv
// Scoreboard bench for apa102_strip_rx: drives bit-level strip traffic and
// checks every decoded pulse against queued expectations.
module tb_apa102_strip_rx;

  localparam int IDX_W   = 6;
  localparam int HALF    = 4;
  localparam int TIMEOUT = 4096;

  logic             clk;
  logic             reset_n;
  logic             sclk_in;
  logic             sdat_in;
  logic             locked;
  logic             pix_valid;
  logic [IDX_W-1:0] pix_idx;
  logic [4:0]       pix_bright;
  logic [7:0]       pix_b;
  logic [7:0]       pix_g;
  logic [7:0]       pix_r;
  logic             frame_done;
  logic [IDX_W:0]   frame_len;
  logic             err;

  apa102_strip_rx dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .sclk_in    (sclk_in),
    .sdat_in    (sdat_in),
    .locked     (locked),
    .pix_valid  (pix_valid),
    .pix_idx    (pix_idx),
    .pix_bright (pix_bright),
    .pix_b      (pix_b),
    .pix_g      (pix_g),
    .pix_r      (pix_r),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // kind: 0 = pixel, 1 = frame_done, 2 = err
  typedef struct {
    int           kind;
    logic [34:0]  pix;
    logic [IDX_W:0] len;
  } ev_t;

  ev_t sb_q[$];
  int  n_checks = 0;
  int  n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_pix(input int idx, input logic [31:0] w);
    ev_t e;
    e.kind = 0;
    e.pix  = {6'(idx), w[28:24], w[23:16], w[15:8], w[7:0]};
    e.len  = '0;
    sb_q.push_back(e);
  endtask

  task automatic push_done(input int len);
    ev_t e;
    e.kind = 1;
    e.pix  = '0;
    e.len  = 7'(len);
    sb_q.push_back(e);
  endtask

  task automatic push_err();
    ev_t e;
    e.kind = 2;
    e.pix  = '0;
    e.len  = '0;
    sb_q.push_back(e);
  endtask

  // Monitor: every pulse pops one expectation.
  always @(negedge clk) begin
    if (reset_n && (pix_valid || frame_done || err)) begin
      int  got_kind;
      ev_t e;
      check_eq("pulse_onehot", 64'($countones({pix_valid, frame_done, err})), 64'd1);
      got_kind = err ? 2 : (frame_done ? 1 : 0);
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected", 64'({pix_valid, frame_done, err}), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check_eq("ev_kind", 64'(got_kind), 64'(e.kind));
        if (e.kind == 0)
          check_eq("pix_fields", 64'({pix_idx, pix_bright, pix_b, pix_g, pix_r}), 64'(e.pix));
        else if (e.kind == 1)
          check_eq("frame_len", 64'(frame_len), 64'(e.len));
        $display("event kind=%0d idx=%0d r=0x%0h len=%0d", got_kind, pix_idx, pix_r, frame_len);
      end
    end
  end

  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    sdat_in = b;
    sclk_in = 1'b1;
    repeat (HALF) @(posedge clk);
    #1 sclk_in = 1'b0;
    repeat (HALF) @(posedge clk);
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic drain(input string tag);
    repeat (10) @(posedge clk);
    #1 check_eq(tag, 64'(sb_q.size()), 64'd0);
    sb_q.delete();
  endtask

  initial begin
    logic [31:0] w;
    reset_n = 1'b0;
    sclk_in = 1'b0;
    sdat_in = 1'b0;
    repeat (3) @(posedge clk);
    #1 check_eq("reset_outputs",
                64'({locked, pix_valid, pix_idx, pix_bright, pix_b, pix_g, pix_r, frame_done, frame_len, err}), 64'd0);
    reset_n = 1'b1;

    // T1: lock, single pixel
    send_zeros(32);
    check_eq("t1_locked", 64'(locked), 64'd1);
    w = 32'hF00F0000;
    push_pix(0, w);
    send_word(w);
    drain("t1_drain");

    // T2: closing zero word ends the 1-pixel frame, then 64 pixels
    push_done(1);
    send_zeros(32);
    for (int i = 0; i < 64; i++) begin
      w = 32'hE0000000 + 32'(i);
      push_pix(i, w);
      send_word(w);
    end
    push_done(64);
    send_zeros(64);
    drain("t2_drain");
    check_eq("t2_hold_pix_r", 64'(pix_r), 64'd63);
    check_eq("t2_hold_len", 64'(frame_len), 64'd64);

    // T3: bad header
    push_err();
    send_word(32'h40000000);
    check_eq("t3_unlocked", 64'(locked), 64'd0);
    drain("t3_drain");
    send_zeros(32);
    check_eq("t3_relock", 64'(locked), 64'd1);

    // T4: strip-clock stall mid-word
    w = 32'hE0000000;
    for (int i = 31; i >= 22; i--) send_bit(w[i]);
    push_err();
    repeat (TIMEOUT + 50) @(posedge clk);
    #1 check_eq("t4_unlocked", 64'(locked), 64'd0);
    drain("t4_drain");
    send_zeros(32);
    check_eq("t4_relock", 64'(locked), 64'd1);

    // T5: overflow past NUM_LEDS
    for (int i = 0; i < 65; i++) begin
      w = 32'hE1000000 + 32'(i * 3);
      if (i < 64) push_pix(i, w);
      else push_err();
      send_word(w);
    end
    push_done(64);
    send_zeros(32);
    check_eq("t5_locked", 64'(locked), 64'd1);
    drain("t5_drain");

    // T6: async reset mid-word
    w = 32'hE0000011;
    push_pix(0, w);
    send_word(w);
    drain("t6_pre_drain");
    w = 32'hE0000022;
    for (int i = 31; i >= 17; i--) send_bit(w[i]);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1 check_eq("t6_async_reset",
                64'({locked, pix_valid, pix_idx, pix_bright, pix_b, pix_g, pix_r, frame_done, frame_len, err}), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    send_word(32'hFF000000);
    send_word(32'hE0000005);
    check_eq("t6_still_hunting", 64'(locked), 64'd0);
    drain("t6_no_events");
    send_zeros(32);
    check_eq("t6_relock", 64'(locked), 64'd1);
    w = 32'hE3123456;
    push_pix(0, w);
    send_word(w);
    push_done(1);
    send_zeros(32);
    drain("t6_drain");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
